// File: rtl/spi_ahb_loader.sv
// rtl/spi_ahb_loader.sv - SPI mode-0 slave that turns load/readback frames into single-beat AHB-Lite transfers.
module spi_ahb_loader #(
  parameter logic [7:0] CMD_WRITE   = 8'h02,
  parameter logic [7:0] CMD_READ    = 8'h03,
  parameter logic [3:0] HPROT_VAL   = 4'b0011,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic [31:0] spi_haddr,
  output logic [31:0] spi_hwdata,
  output logic        spi_hwrite,
  output logic [2:0]  spi_hsize,
  output logic [2:0]  spi_hburst,
  output logic [1:0]  spi_htrans,
  output logic [3:0]  spi_hprot,
  output logic        spi_hmastlock,
  input  logic [31:0] spi_hrdata,
  input  logic        spi_hready,
  input  logic        spi_hresp,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, DUMMY, RDATA, IGNORE} frame_state_t;
  typedef enum logic [1:0] {A_IDLE, A_ADDR, A_DATA} ahb_state_t;

  frame_state_t r_fstate;
  ahb_state_t   r_astate;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_csn_sync, r_mosi_sync;
  logic        r_sclk_prev, r_csn_prev;
  logic [5:0]  r_cnt;
  logic [30:0] r_shift;
  logic [30:0] r_tx;
  logic [31:0] r_addr;
  logic        r_is_read;
  logic        r_req_valid, r_req_write;
  logic [31:0] r_req_addr, r_req_wdata;
  logic        r_rd_valid;
  logic [31:0] r_rd_data;

  logic        w_sclk, w_csn, w_mosi;
  logic        w_rise, w_fall, w_csn_fall, w_csn_rise;
  logic [31:0] w_rx_word, w_next_addr, w_tx_word;
  logic        w_buf_take;
  logic        w_post, w_post_rd;
  logic [31:0] w_post_addr, w_post_data;

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_csn       = r_csn_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise      = w_sclk & ~r_sclk_prev;
  assign w_fall      = ~w_sclk & r_sclk_prev;
  assign w_csn_fall  = ~w_csn & r_csn_prev;
  assign w_csn_rise  = w_csn & ~r_csn_prev;
  assign w_rx_word   = {r_shift, w_mosi};
  assign w_next_addr = r_addr + 32'd4;
  assign w_tx_word   = r_rd_valid ? r_rd_data : 32'h0;
  assign w_buf_take  = (r_astate == A_IDLE) && r_req_valid;

  assign spi_hsize     = 3'b010;
  assign spi_hburst    = 3'b000;
  assign spi_hprot     = HPROT_VAL;
  assign spi_hmastlock = 1'b0;
  assign busy = (r_fstate != IDLE) | (r_astate != A_IDLE) | r_req_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_csn_sync  <= '1;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_csn_prev  <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_prev <= w_sclk;
      r_csn_prev  <= w_csn;
    end
  end

  // Requests the frame side hands to the AHB side this cycle.
  always_comb begin
    w_post      = 1'b0;
    w_post_rd   = 1'b0;
    w_post_addr = 32'h0;
    w_post_data = 32'h0;
    if (!w_csn_rise) begin
      case (r_fstate)
        ADDR: if (w_rise && r_cnt == 6'd31 && r_is_read) begin
          w_post      = 1'b1;
          w_post_rd   = 1'b1;
          w_post_addr = {w_rx_word[31:2], 2'b00};
        end
        WDATA: if (w_rise && r_cnt == 6'd31) begin
          w_post      = 1'b1;
          w_post_addr = r_addr;
          w_post_data = w_rx_word;
        end
        RDATA: if (w_fall && r_cnt == 6'd30) begin
          w_post      = 1'b1;
          w_post_rd   = 1'b1;
          w_post_addr = w_next_addr;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fstate    <= IDLE;
      r_astate    <= A_IDLE;
      r_cnt       <= 6'd0;
      r_shift     <= 31'h0;
      r_tx        <= 31'h0;
      r_addr      <= 32'h0;
      r_is_read   <= 1'b0;
      r_req_valid <= 1'b0;
      r_req_write <= 1'b0;
      r_req_addr  <= 32'h0;
      r_req_wdata <= 32'h0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= 32'h0;
      miso        <= 1'b0;
      spi_htrans  <= 2'b00;
      spi_haddr   <= 32'h0;
      spi_hwdata  <= 32'h0;
      spi_hwrite  <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (r_fstate == IDLE && w_csn_fall) err <= 1'b0;

      case (r_astate)
        A_IDLE: if (r_req_valid) begin
          r_req_valid <= 1'b0;
          spi_haddr   <= r_req_addr;
          spi_hwrite  <= r_req_write;
          spi_hwdata  <= r_req_wdata;
          spi_htrans  <= 2'b10;
          r_astate    <= A_ADDR;
        end
        A_ADDR: if (spi_hready) begin
          spi_htrans <= 2'b00;
          r_astate   <= A_DATA;
        end
        A_DATA: if (spi_hready) begin
          if (spi_hresp) err <= 1'b1;
          if (!spi_hwrite) begin
            r_rd_data  <= spi_hresp ? 32'hDEAD_BEEF : spi_hrdata;
            r_rd_valid <= 1'b1;
          end
          r_astate <= A_IDLE;
        end
        default: r_astate <= A_IDLE;
      endcase

      // Single-entry buffer: a post that finds it still occupied is lost.
      if (w_post) begin
        if (r_req_valid && !w_buf_take) begin
          err <= 1'b1;
        end else begin
          r_req_valid <= 1'b1;
          r_req_addr  <= w_post_addr;
          r_req_write <= !w_post_rd;
          r_req_wdata <= w_post_data;
        end
        if (w_post_rd) r_rd_valid <= 1'b0;
      end

      if (w_csn_rise) begin
        r_fstate <= IDLE;
        r_cnt    <= 6'd0;
        miso     <= 1'b0;
      end else begin
        case (r_fstate)
          IDLE: if (w_csn_fall) begin
            r_fstate <= CMD;
            r_cnt    <= 6'd0;
          end
          CMD: if (w_rise) begin
            r_shift <= w_rx_word[30:0];
            r_cnt   <= r_cnt + 6'd1;
            if (r_cnt == 6'd7) begin
              r_cnt <= 6'd0;
              if (w_rx_word[7:0] == CMD_WRITE) begin
                r_is_read <= 1'b0;
                r_fstate  <= ADDR;
              end else if (w_rx_word[7:0] == CMD_READ) begin
                r_is_read <= 1'b1;
                r_fstate  <= ADDR;
              end else begin
                r_fstate <= IGNORE;
              end
            end
          end
          ADDR: if (w_rise) begin
            r_shift <= w_rx_word[30:0];
            r_cnt   <= r_cnt + 6'd1;
            if (r_cnt == 6'd31) begin
              r_cnt    <= 6'd0;
              r_addr   <= {w_rx_word[31:2], 2'b00};
              r_fstate <= r_is_read ? DUMMY : WDATA;
            end
          end
          WDATA: if (w_rise) begin
            r_shift <= w_rx_word[30:0];
            r_cnt   <= r_cnt + 6'd1;
            if (r_cnt == 6'd31) begin
              r_cnt  <= 6'd0;
              r_addr <= w_next_addr;
            end
          end
          DUMMY: begin
            if (w_rise) r_cnt <= r_cnt + 6'd1;
            if (w_fall && r_cnt == 6'd8) begin
              r_tx     <= w_tx_word[30:0];
              miso     <= w_tx_word[31];
              r_cnt    <= 6'd0;
              r_fstate <= RDATA;
              if (!r_rd_valid) err <= 1'b1;
            end
          end
          RDATA: if (w_fall) begin
            if (r_cnt == 6'd31) begin
              r_tx  <= w_tx_word[30:0];
              miso  <= w_tx_word[31];
              r_cnt <= 6'd0;
              if (!r_rd_valid) err <= 1'b1;
            end else begin
              r_tx  <= {r_tx[29:0], 1'b0};
              miso  <= r_tx[30];
              r_cnt <= r_cnt + 6'd1;
              if (r_cnt == 6'd30) r_addr <= w_next_addr;
            end
          end
          IGNORE: miso <= 1'b0;
          default: r_fstate <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_ahb_loader.sv
// tb/tb_spi_ahb_loader.sv - table-driven bench for spi_ahb_loader with a behavioural AHB slave.
module tb_spi_ahb_loader;

  logic        clk = 1'b0, rst = 1'b1;
  logic        sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic        miso;
  logic [31:0] haddr, hwdata;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [1:0]  htrans;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hrdata = 32'h0;
  logic        hready = 1'b1, hresp = 1'b0;
  logic        busy, err;

  spi_ahb_loader dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .spi_haddr(haddr), .spi_hwdata(hwdata), .spi_hwrite(hwrite), .spi_hsize(hsize),
    .spi_hburst(hburst), .spi_htrans(htrans), .spi_hprot(hprot), .spi_hmastlock(hmastlock),
    .spi_hrdata(hrdata), .spi_hready(hready), .spi_hresp(hresp), .busy(busy), .err(err)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return 32'hA5A5_0000 + ((a - 32'h2000) >> 2) + 32'd1;
  endfunction

  // AHB slave: decides hready/hrdata on the falling edge for the next rising edge
  int          cfg_wait = 0;
  bit          cfg_resp = 1'b0;
  bit          dp_active = 1'b0, dp_write = 1'b0;
  int          dp_wait = 0;
  logic [31:0] dp_addr = 32'h0, dp_wdata = 32'h0;
  logic [31:0] q_addr[$], q_data[$];
  bit          q_wr[$];

  initial forever begin
    @(negedge clk);
    if (rst) begin
      dp_active = 1'b0;
      hready    = 1'b1;
      hresp     = 1'b0;
    end else begin
      if (dp_active && dp_wait > 0) begin
        hready = 1'b0;
        hresp  = 1'b0;
        dp_wait--;
        check("hwdata_hold", hwdata, dp_wdata);
        check("htrans_wait", {30'd0, htrans}, 32'd0);
      end else begin
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = 32'h0;
        if (dp_active) begin
          hresp = cfg_resp;
          if (!dp_write) hrdata = rd_model(dp_addr);
          q_addr.push_back(dp_addr);
          q_wr.push_back(dp_write);
          q_data.push_back(hwdata);
          dp_active = 1'b0;
        end
      end
      if (hready && htrans == 2'b10) begin
        dp_active = 1'b1;
        dp_addr   = haddr;
        dp_write  = hwrite;
        dp_wdata  = hwdata;
        dp_wait   = cfg_wait;
        check("ahb_ctrl", {21'd0, hsize, hburst, hprot, hmastlock},
              {21'd0, 3'b010, 3'b000, 4'b0011, 1'b0});
      end
    end
  end

  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    repeat (6) @(negedge clk);
    m = miso;
    sclk = 1'b1;
    repeat (6) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] op, input logic [31:0] addr, input int dbits,
                           input logic [63:0] wbits, output logic [63:0] rbits);
    logic m;
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 7; i >= 0; i--) spi_bit(op[i], m);
    for (int i = 31; i >= 0; i--) spi_bit(addr[i], m);
    if (op == 8'h03) for (int i = 0; i < 8; i++) spi_bit(1'b0, m);
    rbits = 64'h0;
    for (int i = 0; i < dbits; i++) begin
      spi_bit(wbits[63-i], m);
      rbits[63-i] = m;
    end
    repeat (6) @(negedge clk);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_htrans"}, {30'd0, htrans}, 32'd0);
    check({tag, "_haddr"}, haddr, 32'd0);
    check({tag, "_hwdata"}, hwdata, 32'd0);
    check({tag, "_hwrite"}, {31'd0, hwrite}, 32'd0);
    check({tag, "_miso"}, {31'd0, miso}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    int          dbits;
    logic [63:0] wbits;
    int          wait_cyc;
    bit          resp;
    int          ntx;
    logic [95:0] ea;
    logic [63:0] ed;
    bit          exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rbits;
    int          to;
    logic        m;

    vecs[0] = '{8'h02, 32'h0000_1000, 64, 64'h1111_1111_2222_2222, 0, 1'b0, 2,
                {32'h0000_1000, 32'h0000_1004, 32'h0}, 64'h1111_1111_2222_2222, 1'b0};
    vecs[1] = '{8'h03, 32'h0000_2000, 64, 64'h0, 0, 1'b0, 3,
                {32'h0000_2000, 32'h0000_2004, 32'h0000_2008}, 64'hA5A5_0001_A5A5_0002, 1'b0};
    vecs[2] = '{8'h02, 32'h0000_3000, 64, 64'hCAFE_0001_CAFE_0002, 5, 1'b0, 2,
                {32'h0000_3000, 32'h0000_3004, 32'h0}, 64'hCAFE_0001_CAFE_0002, 1'b0};
    vecs[3] = '{8'h02, 32'h0000_5000, 20, 64'hFFFF_F000_0000_0000, 0, 1'b0, 0,
                96'h0, 64'h0, 1'b0};
    vecs[4] = '{8'h7E, 32'h0000_6000, 32, 64'hFFFF_FFFF_0000_0000, 0, 1'b0, 0,
                96'h0, 64'h0, 1'b0};
    vecs[5] = '{8'h02, 32'hFFFF_FFFC, 64, 64'hAAAA_5555_1234_5678, 0, 1'b0, 2,
                {32'hFFFF_FFFC, 32'h0000_0000, 32'h0}, 64'hAAAA_5555_1234_5678, 1'b0};
    vecs[6] = '{8'h03, 32'h0000_4000, 64, 64'h0, 0, 1'b1, 3,
                {32'h0000_4000, 32'h0000_4004, 32'h0000_4008}, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("init");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      cfg_wait = vecs[v].wait_cyc;
      cfg_resp = vecs[v].resp;
      q_addr.delete();
      q_data.delete();
      q_wr.delete();
      run_frame(vecs[v].op, vecs[v].addr, vecs[v].dbits, vecs[v].wbits, rbits);
      to = 0;
      while (busy && to < 200) begin
        @(negedge clk);
        to++;
      end
      check($sformatf("v%0d_idle", v), {31'd0, busy}, 32'd0);
      check($sformatf("v%0d_ntx", v), q_addr.size(), vecs[v].ntx);
      for (int k = 0; k < vecs[v].ntx; k++) begin
        if (k < q_addr.size()) begin
          check($sformatf("v%0d_haddr%0d", v, k), q_addr[k], vecs[v].ea[95-32*k -: 32]);
          check($sformatf("v%0d_hwrite%0d", v, k), {31'd0, q_wr[k]},
                {31'd0, vecs[v].op == 8'h02});
          if (vecs[v].op == 8'h02)
            check($sformatf("v%0d_hwdata%0d", v, k), q_data[k], vecs[v].ed[63-32*k -: 32]);
        end
      end
      if (vecs[v].op != 8'h02) begin
        check($sformatf("v%0d_miso_w0", v), rbits[63:32], vecs[v].ed[63:32]);
        check($sformatf("v%0d_miso_w1", v), rbits[31:0], vecs[v].ed[31:0]);
      end
      check($sformatf("v%0d_err", v), {31'd0, err}, {31'd0, vecs[v].exp_err});
    end

    // err from the failed read is cleared by the next frame start
    cfg_resp = 1'b0;
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    check("errclr_err", {31'd0, err}, 32'd0);
    check("errclr_busy", {31'd0, busy}, 32'd1);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    check("errclr_idle", {31'd0, busy}, 32'd0);

    // reset in the middle of the address phase of a write frame
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 7; i >= 0; i--) spi_bit(((8'h02 >> i) & 8'h01) != 8'h00, m);
    for (int i = 0; i < 10; i++) spi_bit(1'b1, m);
    check("midaddr_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    check("postrst_busy", {31'd0, busy}, 32'd0);
    check("postrst_htrans", {30'd0, htrans}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_ahb_loader.md
Name: spi_ahb_loader

Overview:
- SPI slave (mode 0) that turns serial load/readback frames from an external programmer into single-beat AHB-Lite master transfers.
- Its AHB master port is the spi_h* group consumed by the Router. Used to load program/data memory before the RISC-V core is released, and to read it back for checking.
- SPI pins are oversampled in the clk domain; no second clock.

Parameters:
- CMD_WRITE, 8'h02, opcode for a write frame.
- CMD_READ, 8'h03, opcode for a read frame.
- HPROT_VAL, 4'b0011, constant driven on spi_hprot (non-cacheable, privileged data).
- SYNC_STAGES, 2, flops in the sclk/cs_n/mosi synchronisers (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- sclk  in  1  SPI clock, asynchronous; requires f_clk >= 8x f_sclk.
- cs_n  in  1  SPI chip select, active low, asynchronous.
- mosi  in  1  serial data in, MSB first.
- miso  out  1  serial data out, MSB first.
- spi_haddr  out  32  AHB address.
- spi_hwdata  out  32  AHB write data.
- spi_hwrite  out  1  AHB direction (1 = write).
- spi_hsize  out  3  constant 3'b010 (word).
- spi_hburst  out  3  constant 3'b000 (SINGLE).
- spi_htrans  out  2  2'b00 IDLE or 2'b10 NONSEQ.
- spi_hprot  out  4  constant HPROT_VAL.
- spi_hmastlock  out  1  constant 0.
- spi_hrdata  in  32  AHB read data.
- spi_hready  in  1  AHB transfer done / ready.
- spi_hresp  in  1  AHB response (1 = ERROR).
- busy  out  1  frame active or AHB transfer outstanding.
- err  out  1  sticky error flag.

Behaviour:
- Reset values:
  - spi_htrans=00, spi_haddr=0, spi_hwdata=0, spi_hwrite=0.
  - miso=0, busy=0, err=0.
  - Both FSMs go to IDLE and all shift counters clear.
  - Reset during an AHB data phase drops the transfer.
- Synchronisers: sclk, cs_n and mosi each pass through SYNC_STAGES flops. Rising/falling sclk edges are detected on the synchronised signal.
  - mosi is sampled on the rising edge.
  - miso updates on the falling edge.
- Frame FSM states: IDLE, CMD, ADDR, WDATA, DUMMY, RDATA, IGNORE.
  - IDLE -> CMD on synchronised cs_n falling edge; clears err.
  - CMD: 8 bits.
    - CMD_WRITE -> ADDR (write).
    - CMD_READ -> ADDR (read).
    - Any other opcode -> IGNORE.
  - ADDR: 32 bits. Address register takes bits [31:2]; bits [1:0] are forced to 0.
    - Write frame -> WDATA.
    - Read frame -> DUMMY, and a read request is posted to the AHB FSM immediately.
  - WDATA: each 32 received bits post a write request of {addr, word}, then addr += 4.
  - DUMMY: 8 sclk cycles; miso=0. At the last dummy falling edge the fetched word is loaded into the TX shifter and its MSB is driven -> RDATA.
  - RDATA: shifts 32 bits out.
    - At bit 0 of each word, addr += 4 and the next read is posted (prefetch).
    - The next word loads on the falling edge after the 32nd bit.
  - IGNORE: miso=0 until cs_n rises.
  - cs_n rising edge in any state -> IDLE.
    - A partial write word is discarded.
    - An outstanding AHB transfer still completes.
- Address wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- AHB FSM states: A_IDLE, A_ADDR, A_DATA.
  - A_ADDR: htrans=NONSEQ with haddr/hwrite valid. Advances to A_DATA on the first cycle with hready=1.
  - A_DATA: htrans=IDLE; hwdata is held. Completes on hready=1.
    - For reads, hrdata is captured on that same cycle.
    - If hresp=1 at completion, err is set and the read data is replaced by 32'hDEAD_BEEF.
  - One request buffer is provided. If a new request arrives while the buffer is already full, err is set and the new request is dropped. This cannot happen when f_clk >= 8x f_sclk and hready wait states stay < 16 cycles.
  - Read data not captured by the time the TX word must load: err is set and 32'h0 is shifted out.
- busy = (frame FSM != IDLE) | (AHB FSM != A_IDLE) | request buffer full.
- err stays set until rst or the next frame start.

Test Plan:
- Write frame 02, addr 0000_1000, words 1111_1111 and 2222_2222 with hready=1 -> two NONSEQ writes: haddr 1000 then 1004, correct hwdata, hsize=010, err=0.
- Read frame 03, addr 0000_2000, 8 dummy bits, 64 read bits; slave returns A5A5_0001 then A5A5_0002 -> miso shifts both words MSB first; haddr 2000, 2004, 2008 (prefetch).
- Write with hready held low for 5 cycles in the data phase -> hwdata held stable, no new NONSEQ issued until hready=1, err=0.
- Read with hresp=1 -> err=1 and miso returns DEAD_BEEF; next cs_n fall clears err.
- Abort and bad opcode:
  - cs_n deasserted after 20 data bits of a write -> no AHB write issued, FSM back to IDLE.
  - Opcode 0x7E -> no AHB activity, miso=0.
- Wrap and reset: write at addr FFFF_FFFC with 2 words -> second write at 0000_0000. Assert rst mid-ADDR -> all outputs return to reset values next cycle.
